// File: rtl/m_memarb.sv
// m_memarb: two-requester arbiter sharing one single-port synchronous RAM; define ARB_STATS_EN to add grant/conflict counters
module m_memarb #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_req0,
    input  logic              w_we0,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [DATA_W-1:0] w_din0,
    output logic              w_gnt0,
    output logic              r_vld0,
    output logic [DATA_W-1:0] w_dout0,
    input  logic              w_req1,
    input  logic              w_we1,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [DATA_W-1:0] w_din1,
    output logic              w_gnt1,
    output logic              r_vld1,
    output logic [DATA_W-1:0] w_dout1,
    output logic [ADDR_W-1:0] w_maddr,
    output logic              w_mwe,
    output logic [DATA_W-1:0] w_mdin,
`ifdef ARB_STATS_EN
    output logic [31:0]       r_cnt_gnt0,
    output logic [31:0]       r_cnt_gnt1,
    output logic [31:0]       r_cnt_conf,
`endif
    input  logic [DATA_W-1:0] w_mdout
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic       pick0, force1;
    logic       prio_d, prio_q;
    logic [3:0] wait_d, wait_q;
    logic       rd_d, rd_q;
    logic       sel_d, sel_q;

    // grant selection: port 0 wins when alone or when favoured by the active policy; nothing granted in reset
    always_comb begin
        force1 = wait_q == WAIT_MAX;
        pick0  = w_req0 & (~w_req1 | (PRIO_MODE == 0 ? ~prio_q : ~force1));
        w_gnt0 = ~w_rst & pick0;
        w_gnt1 = ~w_rst & w_req1 & ~pick0;
    end

    // RAM steering from the granted port, bus parked at zero when idle
    always_comb begin
        w_maddr = w_gnt0 ? w_addr0 : w_gnt1 ? w_addr1 : '0;
        w_mwe   = (w_gnt0 & w_we0) | (w_gnt1 & w_we1);
        w_mdin  = w_gnt0 ? w_din0 : w_gnt1 ? w_din1 : '0;
    end

    // next state: round-robin pointer, port-1 starvation counter, pending read and its owner
    always_comb begin
        prio_d = (w_gnt0 | w_gnt1) ? w_gnt0 : prio_q;
        wait_d = (PRIO_MODE == 0 || !w_req1 || w_gnt1) ? 4'd0 : force1 ? wait_q : wait_q + 4'd1;
        rd_d   = (w_gnt0 & ~w_we0) | (w_gnt1 & ~w_we1);
        sel_d  = rd_d ? w_gnt1 : sel_q;
    end

    // state registers
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            prio_q <= 1'b0;
            wait_q <= 4'd0;
            rd_q   <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            wait_q <= wait_d;
            rd_q   <= rd_d;
            sel_q  <= sel_d;
        end
    end

    // a read granted just before reset is dropped, so the pulse is masked while reset is high
    assign r_vld0  = rd_q & ~sel_q & ~w_rst;
    assign r_vld1  = rd_q & sel_q & ~w_rst;
    assign w_dout0 = w_mdout;
    assign w_dout1 = w_mdout;

`ifdef ARB_STATS_EN
    // wrapping grant and conflict counters
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_cnt_gnt0 <= '0;
            r_cnt_gnt1 <= '0;
            r_cnt_conf <= '0;
        end else begin
            r_cnt_gnt0 <= r_cnt_gnt0 + 32'(w_gnt0);
            r_cnt_gnt1 <= r_cnt_gnt1 + 32'(w_gnt1);
            r_cnt_conf <= r_cnt_conf + 32'(w_req0 & w_req1);
        end
    end
`endif

endmodule
